// File: rtl/muldiv_unit32.sv
// muldiv_unit32: iterative radix-2 32-bit multiply/divide producing HI/LO in 33 cycles
module muldiv_unit32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic        r_div, r_neg_q, r_neg_r, r_dz;
  logic [31:0] r_a, r_m;
  logic [63:0] r_acc;
  logic        w_sgn, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_q, w_r;
  logic [32:0] w_add, w_rsh, w_sub;
  logic [63:0] w_mstep, w_dstep, w_prod;
  // operand magnitudes, one iteration of each engine, and final sign correction
  always_comb begin
    w_sgn   = ~op[0];
    w_abs_a = (w_sgn && a[31]) ? -a : a;
    w_abs_b = (w_sgn && b[31]) ? -b : b;
    w_add   = {1'b0, r_acc[63:32]} + {1'b0, r_acc[0] ? r_m : 32'd0};
    w_mstep = {w_add, r_acc[31:1]};
    w_rsh   = r_acc[63:31];
    w_ge    = w_rsh >= {1'b0, r_m};
    w_sub   = w_rsh - {1'b0, r_m};
    w_dstep = w_ge ? {w_sub[31:0], r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
    w_prod  = r_neg_q ? -r_acc : r_acc;
    w_q     = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
    w_r     = r_neg_r ? -r_acc[63:32] : r_acc[63:32];
    busy    = r_state != IDLE;
  end
  // next-state: accept start in IDLE, 32 iterations in RUN, one FIN cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_cnt == 5'd31) ? FIN : RUN) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operand capture, iteration datapath and HI/LO write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 5'd0;
      r_acc   <= 64'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_a     <= 32'd0;
      r_m     <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= r_state == FIN;
      if (r_state == IDLE && start) begin
        r_div   <= op[1];
        r_neg_q <= w_sgn & (a[31] ^ b[31]);
        r_neg_r <= w_sgn & a[31];
        r_dz    <= b == 32'd0;
        r_a     <= a;
        r_m     <= op[1] ? w_abs_b : w_abs_a;
        r_acc   <= {32'd0, op[1] ? w_abs_a : w_abs_b};
        r_cnt   <= 5'd0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 5'd1;
        r_acc <= r_div ? w_dstep : w_mstep;
      end else if (r_state == FIN) begin
        {hi, lo} <= !r_div ? w_prod : r_dz ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit32.sv
// tb_muldiv_unit32: directed and random checks of muldiv_unit32 against an arithmetic model
module tb_muldiv_unit32;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, ndone = 0, nbusy = 0;

  muldiv_unit32 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (o == 2'd0) return sx * sy;
    if (o == 2'd1) return ux * uy;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 2'd3) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) ndone++;
    if (busy) nbusy++;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    nbusy = 0;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc = 0;
    ndone = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp);
    while (!done && cyc < 40) tick();
    chk({tag, "_latency"}, cyc, 33);
    chk({tag, "_busy_cycles"}, nbusy, 33);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] held;
    tick();
    tick();
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    reset = 1'b0;
    tick();
    chk("idle_state", {busy, done}, 2'b00);

    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", {32'hFFFF_FFFE, 32'h0000_0001});
    held = {hi, lo};
    tick();
    chk("done_one_cycle", done, 0);
    chk("hilo_hold", {hi, lo}, held);

    start_op(2'd0, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    start_op(2'd3, 32'd100, 32'd7);
    wait_done("divu", {32'd2, 32'd14});
    start_op(2'd3, 32'd5, 32'd0);
    wait_done("divu_zero", {32'd5, 32'hFFFF_FFFF});
    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", {32'd0, 32'h8000_0000});

    start_op(2'd1, 32'd6, 32'd7);
    repeat (4) tick();
    start = 1'b1;
    op = 2'd1;
    a = 32'd1;
    b = 32'd1;
    tick();
    start = 1'b0;
    wait_done("start_ignored", {32'd0, 32'd42});
    repeat (40) tick();
    chk("single_done_pulse", ndone, 1);

    start_op(2'd3, 32'd100, 32'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", {busy, done, hi, lo}, 66'd0);
    repeat (40) tick();
    chk("abort_no_done", ndone, 0);
    start_op(2'd1, 32'd3, 32'd4);
    wait_done("after_abort", {32'd0, 32'd12});

    start_op(2'd1, 32'd2, 32'd3);
    wait_done("b2b_first", {32'd0, 32'd6});
    start_op(2'd3, 32'd9, 32'd4);
    chk("b2b_hold", {hi, lo}, {32'd0, 32'd6});
    wait_done("b2b_second", {32'd1, 32'd2});

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      rb = (i % 6 == 0) ? 32'd0 : (i % 3 == 1) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 5 == 2) rb = -rb;
      start_op(ro, ra, rb);
      wait_done($sformatf("rand%0d_op%0d", i, ro), model(ro, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
